// File: rtl/dino_pkg.sv
// Shared types and constants for the dino runner: game states, floor height
// and default timing so the jump datapath and the game controller agree.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEAD     = 2'd2,
    WAIT_REL = 2'd3
  } game_state_t;

  localparam logic [7:0]  DINO_FLOOR_Y    = 8'd101;
  localparam int unsigned TICK_DIV_DEF    = 400000;
  localparam int unsigned HOLD_CYC_DEF    = 300000;
  localparam int unsigned DEATH_TICKS_DEF = 64;
  localparam int unsigned SCORE_W_DEF     = 14;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The physics tick only runs while a game is in progress or dying.
  function automatic logic tick_active(input game_state_t s);
    return (s == RUN) || (s == DEAD);
  endfunction

endpackage

// File: rtl/dino_tick_gen.sv
// Physics-tick prescaler: counts TICK_DIV clocks while enabled and emits a
// registered one-cycle pulse after each terminal count.
module dino_tick_gen
  import dino_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] TC_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (clr || !en) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TC_LAST) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner game sequencer: button qualification, game FSM, physics tick,
// jump request and score / high-score bookkeeping.
//
// state    | meaning
// IDLE     | waiting for a qualified press to start a game
// RUN      | game running, obstacles scroll, presses on the floor jump
// DEAD     | collision seen, waiting DEATH_TICKS physics ticks
// WAIT_REL | death time over, waiting for the button to be released
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned DEATH_TICKS = DEATH_TICKS_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic               dino_on_floor,
  input  logic               collision,
  output logic               phys_tick,
  output logic               jump_req,
  output logic               run_en,
  output logic               game_over,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam int unsigned HW = cnt_width(HOLD_CYC + 1);
  localparam int unsigned DW = cnt_width(DEATH_TICKS);
  localparam logic [HW-1:0]      HOLD_MAX   = HW'(HOLD_CYC);
  localparam logic [HW-1:0]      HOLD_ARM   = HW'(HOLD_CYC - 1);
  localparam logic [DW-1:0]      DEATH_LAST = DW'(DEATH_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  game_state_t        st_q, st_nxt;
  logic [HW-1:0]      hold_cnt;
  logic               btn_q;
  logic [DW-1:0]      death_cnt, death_nxt;
  logic [SCORE_W-1:0] score_nxt, hi_nxt;
  logic               jump_nxt;
  logic               tick_en, tick_clr;

  // One pulse per press: fires only on the HOLD_CYC-1 -> HOLD_CYC step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      btn_q    <= 1'b0;
    end else begin
      btn_q <= button && (hold_cnt == HOLD_ARM);
      if (!button) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign tick_en  = tick_active(st_q);
  assign tick_clr = (st_nxt != st_q);

  dino_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .tick(phys_tick)
  );

  always_comb begin
    st_nxt    = st_q;
    jump_nxt  = 1'b0;
    score_nxt = score;
    hi_nxt    = hi_score;
    death_nxt = death_cnt;
    unique case (st_q)
      IDLE: begin
        if (btn_q) begin
          st_nxt    = RUN;
          score_nxt = '0;
        end
      end
      RUN: begin
        // Collision wins over a coincident tick or press.
        if (collision) begin
          st_nxt    = DEAD;
          death_nxt = '0;
          if (score > hi_score) hi_nxt = score;
        end else begin
          if (phys_tick && (score != SCORE_MAX)) score_nxt = score + 1'b1;
          if (btn_q && dino_on_floor) jump_nxt = 1'b1;
        end
      end
      DEAD: begin
        if (phys_tick) begin
          if (death_cnt == DEATH_LAST) begin
            st_nxt    = WAIT_REL;
            death_nxt = '0;
          end else begin
            death_nxt = death_cnt + 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (hold_cnt == '0) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      jump_req  <= 1'b0;
      run_en    <= 1'b0;
      game_over <= 1'b0;
      score     <= '0;
      hi_score  <= '0;
      death_cnt <= '0;
    end else begin
      st_q      <= st_nxt;
      jump_req  <= jump_nxt;
      run_en    <= (st_nxt == RUN);
      game_over <= (st_nxt == DEAD) || (st_nxt == WAIT_REL);
      score     <= score_nxt;
      hi_score  <= hi_nxt;
      death_cnt <= death_nxt;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: directed game scenarios followed by random play,
// every cycle compared against a behavioural model of the game rules.
module tb_dino_game_ctrl;

  localparam int TD   = 4;
  localparam int HC   = 3;
  localparam int DT   = 2;
  localparam int SW   = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          button;
  logic          dino_on_floor;
  logic          collision;
  logic          phys_tick;
  logic          jump_req;
  logic          run_en;
  logic          game_over;
  logic [1:0]    state;
  logic [SW-1:0] score;
  logic [SW-1:0] hi_score;

  int n_checks = 0;
  int n_errors = 0;

  // model: state as 0..3, age = cycles since entering the state,
  // press = consecutive high button samples (unbounded)
  int m_state, m_score, m_hi, m_age, m_press;
  bit m_tick, m_jump;

  always #5 clk = ~clk;

  dino_game_ctrl #(
    .TICK_DIV   (TD),
    .HOLD_CYC   (HC),
    .DEATH_TICKS(DT),
    .SCORE_W    (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .dino_on_floor(dino_on_floor),
    .collision    (collision),
    .phys_tick    (phys_tick),
    .jump_req     (jump_req),
    .run_en       (run_en),
    .game_over    (game_over),
    .state        (state),
    .score        (score),
    .hi_score     (hi_score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_age = 0; m_press = 0;
    m_tick = 1'b0; m_jump = 1'b0;
  endtask

  task automatic model_edge();
    int  ns, nsc, nhi;
    bit  nj, q;
    if (rst) begin
      model_reset();
    end else begin
      ns = m_state; nsc = m_score; nhi = m_hi; nj = 1'b0;
      q = (m_press == HC);
      case (m_state)
        0: if (q) begin ns = 1; nsc = 0; end
        1: begin
          if (collision) begin
            ns = 2;
            if (m_score > m_hi) nhi = m_score;
          end else begin
            if (m_tick && m_score < SMAX) nsc = m_score + 1;
            nj = q && dino_on_floor;
          end
        end
        2: if (m_tick && (m_age / TD) >= DT) ns = 3;
        default: if (m_press == 0) ns = 0;
      endcase
      m_age   = (ns != m_state) ? 0 : m_age + 1;
      m_state = ns;
      m_score = nsc;
      m_hi    = nhi;
      m_jump  = nj;
      m_press = button ? m_press + 1 : 0;
      m_tick  = (ns == 1 || ns == 2) && m_age > 0 && (m_age % TD) == 0;
    end
  endtask

  task automatic check_all();
    chk("phys_tick", 32'(phys_tick), 32'(m_tick));
    chk("jump_req",  32'(jump_req),  32'(m_jump));
    chk("run_en",    32'(run_en),    32'(m_state == 1));
    chk("game_over", 32'(game_over), 32'(m_state >= 2));
    chk("state",     32'(state),     32'(m_state));
    chk("score",     32'(score),     32'(m_score));
    chk("hi_score",  32'(hi_score),  32'(m_hi));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_state(input int s, input int limit, input string tag);
    int i = 0;
    while (state !== 2'(s) && i < limit) begin
      step();
      i++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_score(input int s, input int limit, input string tag);
    int i = 0;
    while (score !== SW'(s) && i < limit) begin
      step();
      i++;
    end
    chk(tag, 32'(score), 32'(s));
  endtask

  task automatic start_game();
    button = 1'b1;
    steps(HC);
    button = 1'b0;
    step();
  endtask

  initial begin
    int pulses;
    int i;
    rst = 1'b1; button = 1'b0; dino_on_floor = 1'b1; collision = 1'b0;
    model_reset();
    steps(2);
    chk("reset_state", 32'(state), 0);
    chk("reset_hi", 32'(hi_score), 0);
    rst = 1'b0;
    step();

    // start press: RUN, score 0, no jump, tick every TD clocks
    button = 1'b1;
    steps(HC);
    chk("still_idle", 32'(state), 0);
    button = 1'b0;
    step();
    chk("start_state", 32'(state), 1);
    chk("start_score", 32'(score), 0);
    chk("start_no_jump", 32'(jump_req), 0);
    pulses = 0;
    repeat (2 * TD) begin
      step();
      if (phys_tick) pulses++;
    end
    chk("tick_count", 32'(pulses), 2);

    // jump on floor, long hold gives only one pulse
    button = 1'b1;
    steps(HC);
    step();
    chk("jump_pulse", 32'(jump_req), 1);
    pulses = 0;
    repeat (20) begin
      step();
      if (jump_req) pulses++;
    end
    chk("jump_hold_extra", 32'(pulses), 0);
    button = 1'b0;
    step();

    // airborne press dropped, no late jump on landing
    dino_on_floor = 1'b0;
    button = 1'b1;
    steps(HC);
    step();
    chk("air_no_jump", 32'(jump_req), 0);
    dino_on_floor = 1'b1;
    pulses = 0;
    repeat (6) begin
      step();
      if (jump_req) pulses++;
    end
    chk("no_late_jump", 32'(pulses), 0);
    button = 1'b0;
    step();

    // saturate, then collide on a tick cycle
    steps(20 * TD);
    chk("score_sat", 32'(score), SMAX);
    i = 0;
    while (phys_tick !== 1'b1 && i < 2 * TD) begin
      step();
      i++;
    end
    chk("tick_found", 32'(phys_tick), 1);
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("dead_state", 32'(state), 2);
    chk("dead_score", 32'(score), SMAX);
    chk("dead_hi", 32'(hi_score), SMAX);

    // button held through death: WAIT_REL until release, then IDLE
    button = 1'b1;
    steps(DT * TD);
    chk("dead_last", 32'(state), 2);
    step();
    chk("wait_rel", 32'(state), 3);
    steps(5);
    chk("wait_held", 32'(state), 3);
    button = 1'b0;
    step();
    chk("wait_release", 32'(state), 3);
    step();
    chk("back_idle", 32'(state), 0);
    button = 1'b1;
    steps(HC - 1);
    button = 1'b0;
    steps(3);
    chk("short_press", 32'(state), 0);
    start_game();
    chk("restart", 32'(state), 1);

    // hi_score 5, then reset mid-RUN at score 7
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start_game();
    wait_score(5, 40, "reach5");
    collision = 1'b1;
    step();
    collision = 1'b0;
    chk("hi5", 32'(hi_score), 5);
    wait_state(0, 60, "idle_after5");
    start_game();
    wait_score(7, 60, "reach7");
    chk("hi5_kept", 32'(hi_score), 5);
    rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_score", 32'(score), 0);
    chk("async_hi", 32'(hi_score), 0);
    chk("async_run_en", 32'(run_en), 0);
    step();
    rst = 1'b0;
    step();

    // random play
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) button = ~button;
      if ($urandom_range(0, 5) == 0) dino_on_floor = ~dino_on_floor;
      collision = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
